// File: rtl/mul32_seq_karatsuba.sv
// mul32_seq_karatsuba: iterative unsigned 32x32 -> 64 multiplier.
// Each operand is split into 16-bit halves. The four half-products are formed one per cycle by a
// single combinational 16x16 Karatsuba core and accumulated with shifts into a 64-bit sum.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid          in_ready   accepting operands (IDLE only)
//   in_a/in_b  unsigned 32-bit operands
//   out_valid  product valid, held until out_ready
//   out_ready  downstream accepts product  out_p      64-bit unsigned product
module mul32_seq_karatsuba #(
  parameter int unsigned HALF_W = 16,
  localparam int unsigned OP_W = 2 * HALF_W,
  localparam int unsigned PROD_W = 2 * OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Karatsuba split of the 16-bit core operands into quarter-width pieces.
  localparam int unsigned QW = HALF_W / 2;
  localparam int unsigned MW = 2 * QW + 2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] out_p_q, out_p_d;

  logic [HALF_W-1:0] core_a, core_b;
  logic [OP_W-1:0]   core_p;
  logic [MW-1:0]     ka_lo, ka_hi, kb_lo, kb_hi;
  logic [MW-1:0]     kz0, kz2, kzm, kz1;
  logic [PROD_W-1:0] term, sum;

  // step[1] selects the high half of a, step[0] the high half of b.
  always_comb begin
    core_a = step_q[1] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
    core_b = step_q[0] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];
  end

  // Combinational 16x16 Karatsuba core: three narrow multiplies instead of four.
  always_comb begin
    ka_lo  = MW'(core_a[QW-1:0]);
    ka_hi  = MW'(core_a[HALF_W-1:QW]);
    kb_lo  = MW'(core_b[QW-1:0]);
    kb_hi  = MW'(core_b[HALF_W-1:QW]);
    kz0    = ka_lo * kb_lo;
    kz2    = ka_hi * kb_hi;
    kzm    = (ka_lo + ka_hi) * (kb_lo + kb_hi);
    // Cross term is non-negative and fits in MW bits.
    kz1    = kzm - kz0 - kz2;
    core_p = (OP_W'(kz2) << (2 * QW)) + (OP_W'(kz1) << QW) + OP_W'(kz0);
  end

  // Align the zero-extended half-product to its weight.
  always_comb begin
    unique case (step_q)
      2'd0:    term = PROD_W'(core_p);
      2'd1,
      2'd2:    term = PROD_W'(core_p) << HALF_W;
      default: term = PROD_W'(core_p) << OP_W;
    endcase
    sum = acc_q + term;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_p_d = out_p_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          step_d  = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d  = sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          out_p_d = sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_p_q <= out_p_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_mul32_seq_karatsuba.sv
module tb_mul32_seq_karatsuba;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [63:0] out_p;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[6];

  mul32_seq_karatsuba dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_p    (out_p)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return {16'h0, 16'(($urandom))};
      3:       return {16'(($urandom)), 16'hFFFF};
      default: return 32'($urandom);
    endcase
  endfunction

  // Present operands at a negedge once in_ready is seen; returns at the negedge after acceptance
  // with the operand bus scrambled to prove the in-flight value was latched.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int lat;
    out_ready = 1'b0;
    send(a, b);
    wait_result(lat);
    chk({name, "_latency"}, 64'(lat), 64'd4);
    chk({name, "_p"}, out_p, exp);
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({name, "_ready_back"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] q[$];
    int lat, sent, got, cyc;
    bit acc_prev;

    vecs[0] = '{32'h0001_FFFF, 32'h0000_0002, 64'h0000_0000_0003_FFFE};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0};
    vecs[3] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[4] = '{32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678};
    vecs[5] = '{32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_p", out_p, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);

    // Backpressure: result held for 10 cycles while new operands are offered and ignored.
    send(32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_result(lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_p", out_p, 64'hDEAD_BEEF * 64'hCAFE_F00D);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    run_vec("after_bp", 32'h0000_0007, 32'h0000_0009, 64'd63);

    // Reset while the multiply is at step 2.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_out_p", out_p, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", 32'd3, 32'd5, 64'd15);

    // Random stream with random valid/ready against a plain a*b model.
    sent     = 0;
    got      = 0;
    cyc      = 0;
    acc_prev = 1'b0;
    while (got < 500 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc_prev) in_valid = 1'b0;
      if (!in_valid && sent < 500 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a     = rnd32();
        in_b     = rnd32();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc_prev  = in_valid && in_ready;
      if (acc_prev) begin
        q.push_back(64'(in_a) * 64'(in_b));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_duplicate", 64'd1, 64'd0);
        else chk($sformatf("rand_p%0d", got), out_p, q.pop_front());
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_count", 64'(got), 64'd500);
    chk("rand_queue_empty", 64'(q.size()), 64'd0);
    repeat (8) begin
      @(negedge clk);
      chk("rand_no_extra", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
